// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage : registered RV32I decode stage with valid/ready handshake
// Revision     : 1.0
// ============================================================================
module decode_stage #(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 16,
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  pc_out,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [3:0]       alu_control,
  output logic             alu_src,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             branch,
  output logic             jump,
  output logic [2:0]       mem_funct3,
  output logic             illegal,
  output logic [CNT_W-1:0] decode_count
);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IALU   = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] c_ALU_AND   = 4'b0000;
  localparam logic [3:0] c_ALU_OR    = 4'b0001;
  localparam logic [3:0] c_ALU_ADD   = 4'b0010;
  localparam logic [3:0] c_ALU_XOR   = 4'b0011;
  localparam logic [3:0] c_ALU_SLL   = 4'b0100;
  localparam logic [3:0] c_ALU_SRL   = 4'b0101;
  localparam logic [3:0] c_ALU_SUB   = 4'b0110;
  localparam logic [3:0] c_ALU_SRA   = 4'b0111;
  localparam logic [3:0] c_ALU_SLT   = 4'b1000;
  localparam logic [3:0] c_ALU_SLTU  = 4'b1001;
  localparam logic [3:0] c_ALU_PASSB = 4'b1010;

  localparam logic [6:0] c_F7_BASE   = 7'b0000000;
  localparam logic [6:0] c_F7_ALT    = 7'b0100000;

  logic [6:0]         w_opcode;
  logic [2:0]         w_f3;
  logic [6:0]         w_f7;
  logic [3:0]         w_alu;
  logic               w_alu_src;
  logic               w_reg_write;
  logic               w_mem_read;
  logic               w_mem_write;
  logic               w_mem_to_reg;
  logic               w_branch;
  logic               w_jump;
  logic               w_illegal;
  logic signed [31:0] w_imm32;
  logic               w_accept;
  logic               w_keep;
  logic               w_load;

  logic               r_valid;
  logic [XLEN-1:0]    r_pc;
  logic [4:0]         r_rs1;
  logic [4:0]         r_rs2;
  logic [4:0]         r_rd;
  logic [XLEN-1:0]    r_imm;
  logic [3:0]         r_alu;
  logic               r_alu_src;
  logic               r_reg_write;
  logic               r_mem_read;
  logic               r_mem_write;
  logic               r_mem_to_reg;
  logic               r_branch;
  logic               r_jump;
  logic [2:0]         r_f3;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_count;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];

  always_comb begin
    w_alu        = c_ALU_ADD;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_illegal    = 1'b0;
    w_imm32      = '0;
    case (w_opcode)
      c_OP_R: begin
        w_reg_write = 1'b1;
        case (w_f3)
          3'b000:  w_alu = w_f7[5] ? c_ALU_SUB : c_ALU_ADD;
          3'b001:  w_alu = c_ALU_SLL;
          3'b010:  w_alu = c_ALU_SLT;
          3'b011:  w_alu = c_ALU_SLTU;
          3'b100:  w_alu = c_ALU_XOR;
          3'b101:  w_alu = w_f7[5] ? c_ALU_SRA : c_ALU_SRL;
          3'b110:  w_alu = c_ALU_OR;
          default: w_alu = c_ALU_AND;
        endcase
        // Only sub and sra own the alternate funct7 encoding.
        if (!((w_f7 == c_F7_BASE) ||
              ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))))
          w_illegal = 1'b1;
      end
      c_OP_IALU: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_imm32     = {{20{instr[31]}}, instr[31:20]};
        case (w_f3)
          3'b000:  w_alu = c_ALU_ADD;
          3'b001: begin
            w_alu = c_ALU_SLL;
            if (w_f7 != c_F7_BASE) w_illegal = 1'b1;
          end
          3'b010:  w_alu = c_ALU_SLT;
          3'b011:  w_alu = c_ALU_SLTU;
          3'b100:  w_alu = c_ALU_XOR;
          3'b101: begin
            w_alu = w_f7[5] ? c_ALU_SRA : c_ALU_SRL;
            if ((w_f7 != c_F7_BASE) && (w_f7 != c_F7_ALT)) w_illegal = 1'b1;
          end
          3'b110:  w_alu = c_ALU_OR;
          default: w_alu = c_ALU_AND;
        endcase
      end
      c_OP_LOAD: begin
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_imm32      = {{20{instr[31]}}, instr[31:20]};
        if ((w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111)) w_illegal = 1'b1;
      end
      c_OP_STORE: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_imm32     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        if (w_f3 > 3'b010) w_illegal = 1'b1;
      end
      c_OP_BRANCH: begin
        w_alu    = c_ALU_SUB;
        w_branch = 1'b1;
        w_imm32  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        if ((w_f3 == 3'b010) || (w_f3 == 3'b011)) w_illegal = 1'b1;
      end
      c_OP_JAL: begin
        w_jump      = 1'b1;
        w_reg_write = 1'b1;
        w_imm32     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      c_OP_JALR: begin
        w_jump      = 1'b1;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_imm32     = {{20{instr[31]}}, instr[31:20]};
        if (w_f3 != 3'b000) w_illegal = 1'b1;
      end
      c_OP_LUI: begin
        w_alu       = c_ALU_PASSB;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_imm32     = {instr[31:12], 12'b0};
      end
      c_OP_AUIPC: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_imm32     = {instr[31:12], 12'b0};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  // With trapping disabled an illegal instruction is consumed but never presented.
  assign w_keep   = !w_illegal || (TRAP_ILLEGAL != 0);
  assign w_load   = w_accept && !flush && w_keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_imm        <= '0;
      r_alu        <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_f3         <= '0;
      r_illegal    <= 1'b0;
      r_count      <= '0;
    end else begin
      if (flush)
        r_valid <= 1'b0;
      else if (w_load)
        r_valid <= 1'b1;
      else if (r_valid && out_ready)
        r_valid <= 1'b0;

      if (w_load) begin
        r_pc         <= pc_in;
        r_rs1        <= instr[19:15];
        r_rs2        <= instr[24:20];
        r_rd         <= instr[11:7];
        r_imm        <= XLEN'(w_imm32);
        r_alu        <= w_alu;
        r_alu_src    <= w_alu_src;
        r_reg_write  <= w_reg_write  && !w_illegal;
        r_mem_read   <= w_mem_read   && !w_illegal;
        r_mem_write  <= w_mem_write  && !w_illegal;
        r_mem_to_reg <= w_mem_to_reg && !w_illegal;
        r_branch     <= w_branch     && !w_illegal;
        r_jump       <= w_jump       && !w_illegal;
        r_f3         <= w_f3;
        r_illegal    <= w_illegal;
      end

      if (r_valid && out_ready && !flush)
        r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_valid    = r_valid;
  assign pc_out       = r_pc;
  assign rs1          = r_rs1;
  assign rs2          = r_rs2;
  assign rd           = r_rd;
  assign imm          = r_imm;
  assign alu_control  = r_alu;
  assign alu_src      = r_alu_src;
  assign reg_write    = r_reg_write;
  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign mem_to_reg   = r_mem_to_reg;
  assign branch       = r_branch;
  assign jump         = r_jump;
  assign mem_funct3   = r_f3;
  assign illegal      = r_illegal;
  assign decode_count = r_count;

endmodule
`default_nettype wire
